// File: rtl/ksa_mp_sequencer.sv
// Multi-precision add/subtract sequencer: streams 1..MAX_WORDS operand words LSW-first
// through a single 32-bit Kogge-Stone adder, chaining the carry between words.

module KSA_top_level #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic [WIDTH:0]   w_c;

    // Log-depth prefix tree; after the loop w_g/w_p hold group generate/propagate of bits [i:0].
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_gn = w_g;
        w_pn = w_p;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = s; i < WIDTH; i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i-s]);
                w_pn[i] = w_p[i] & w_p[i-s];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        w_c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & cin);
        end
        sum  = (a ^ b) ^ w_c[WIDTH-1:0];
        cout = w_c[WIDTH];
    end
endmodule

// States:
//   S_IDLE  | waiting for a command, cmd_ready high
//   S_RUN   | accepting operand words, one adder pass per word
//   S_DRAIN | last result word held until downstream takes it
module ksa_mp_sequencer #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 8,
    parameter int LW        = $clog2(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic [LW-1:0]    cmd_len,
    input  logic             cmd_cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_flag,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sub;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_last;
    logic             r_out_flag;

    logic             w_cmd_fire;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_last;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Subtraction is a + ~b + ~borrow; the borrow-out is the inverted carry-out.
    assign w_add_b    = r_sub ? ~in_b : in_b;
    assign w_last     = (r_cnt == r_len);
    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    KSA_top_level #(.WIDTH(WIDTH)) u_ksa (
        .a    (in_a),
        .b    (w_add_b),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // cmd_ready is gated by rst_n so it reads 0 for the whole reset assertion.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (w_cmd_fire) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = ~r_out_valid | out_ready;
                if (w_in_fire && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_out_fire) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub       <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_flag  <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_sub   <= cmd_sub;
                r_len   <= cmd_len;
                r_carry <= cmd_sub ? ~cmd_cin : cmd_cin;
                r_cnt   <= '0;
            end
            if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum;
                r_out_last  <= w_last;
                r_out_flag  <= w_last & (r_sub ^ w_cout);
                r_carry     <= w_cout;
                r_cnt       <= r_cnt + 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_flag  = r_out_flag;
endmodule

// File: tb/tb_ksa_mp_sequencer.sv
// Bench for ksa_mp_sequencer: wide-integer reference model, per-cycle output scoreboard,
// directed cases with literal expectations, and a randomized regression.

module tb_ksa_mp_sequencer;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sub;
    logic [2:0]  cmd_len;
    logic        cmd_cin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_last;
    logic        out_flag;
    logic        busy;

    ksa_mp_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sub   (cmd_sub),
        .cmd_len   (cmd_len),
        .cmd_cin   (cmd_cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_flag  (out_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        last;
        logic        flag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          cyc_cmd = 0;
    int          cyc_last = 0;
    bit          seen_last = 0;
    int          last_cnt = 0;
    logic [31:0] last_sum = '0;
    logic        last_flag = 1'b0;
    bit          busy_exp = 0;
    bit          in_run = 0;
    bit          drop_pending = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-operand arithmetic on n words; flag is carry-out (add) or borrow-out (sub).
    task automatic model(input bit sub, input int n, input bit cin,
                         input logic [255:0] a, input logic [255:0] b,
                         output logic [255:0] r, output bit flag);
        logic [288:0] m;
        logic [288:0] aw;
        logic [288:0] bw;
        logic [288:0] rw;
        m  = (289'd1 << (32 * n)) - 289'd1;
        aw = {33'd0, a} & m;
        bw = {33'd0, b} & m;
        if (sub) begin
            rw   = aw - bw - 289'(cin);
            flag = (aw < bw + 289'(cin));
        end else begin
            rw   = aw + bw + 289'(cin);
            flag = rw[32 * n];
        end
        rw = rw & m;
        r  = rw[255:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            drop_pending = 0;
        end else begin
            if (drop_pending) begin
                busy_exp     = 0;
                drop_pending = 0;
            end
            chk("busy", 64'(busy), 64'(busy_exp));
            chk("cmd_ready", 64'(cmd_ready), 64'(!busy_exp));
            chk("in_ready", 64'(in_ready), 64'(in_run && (!out_valid || out_ready)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("out_sum", 64'(out_sum), 64'(e.sum));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("out_flag", 64'(out_flag), 64'(e.flag));
                    if (out_last && !seen_last) begin
                        seen_last = 1;
                        cyc_last  = cyc;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (out_last) begin
                            last_cnt++;
                            last_sum  = out_sum;
                            last_flag = out_flag;
                        end
                        if (e.last) drop_pending = 1;
                    end
                end
            end
        end
    end

    // mode: 0 = out_ready high, 1 = random out_ready, 2 = 3-cycle stall after word 2.
    task automatic run_op(input bit sub, input int n, input bit cin,
                          input logic [255:0] a, input logic [255:0] b,
                          input int mode, input bit gaps, input int abort_at);
        logic [255:0] r;
        bit           flag;
        exp_t         e;
        int           k;
        int           t;
        int           stall;
        bit           stalling;
        bit           fire;
        model(sub, n, cin, a, b, r, flag);
        for (int i = 0; i < n; i++) begin
            e.sum  = r[32*i +: 32];
            e.last = (i == n - 1);
            e.flag = (i == n - 1) ? flag : 1'b0;
            exp_q.push_back(e);
        end
        last_cnt  = 0;
        seen_last = 0;
        t = 0;
        while (!cmd_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1;
        cmd_sub   = sub;
        cmd_len   = 3'(n - 1);
        cmd_cin   = cin;
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        tick();
        cmd_valid = 1'b0;
        busy_exp  = 1;
        in_run    = 1;
        cyc_cmd   = cyc;
        cmd_sub   = 1'($urandom);
        cmd_len   = 3'($urandom);
        cmd_cin   = 1'($urandom);
        k = 0;
        t = 0;
        stall = 0;
        while ((k < n || exp_q.size() > 0) && t < 3000) begin
            if (k < n) begin
                in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_a     = a[32*k +: 32];
                in_b     = b[32*k +: 32];
            end else begin
                in_valid = 1'($urandom);
                in_a     = $urandom;
                in_b     = $urandom;
            end
            stalling = 0;
            if (mode == 2 && stall > 0) begin
                out_ready = 1'b0;
                stall--;
                stalling = 1;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (stalling) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_out_sum", 64'(out_sum), 64'(r[63:32]));
            end
            fire = in_valid && in_ready && (k < n);
            tick();
            t++;
            if (abort_at > 0 && fire && k + 1 == abort_at) begin
                rst_n    = 1'b0;
                exp_q.delete();
                busy_exp = 0;
                in_run   = 0;
                #1;
                chk("abort_out_valid", 64'(out_valid), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
                in_valid = 1'b0;
                return;
            end
            if (fire) begin
                k++;
                if (k == n) in_run = 0;
                if (mode == 2 && k == 2) stall = 3;
            end
        end
        if (t >= 3000) chk("op_timeout", 64'd0, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("last_count", 64'(last_cnt), 64'd1);
    endtask

    initial begin
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] r;
        bit           flag;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sub   = 1'b0;
        cmd_len   = 3'd0;
        cmd_cin   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        model(1'b1, 1, 1'b0, 256'd10888, 256'd98712, r, flag);
        chk("model_pin_sub", 64'(r[31:0]), 64'hFFFEA8F0);
        chk("model_pin_borrow", 64'(flag), 64'd1);
        model(1'b0, 2, 1'b0, 256'hFFFFFFFF, 256'h1, r, flag);
        chk("model_pin_chain", 64'(r[63:0]), 64'h0000000100000000);

        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_flag", 64'(out_flag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();

        run_op(1'b0, 1, 1'b0, 256'd18, 256'd999, 0, 1'b0, 0);
        chk("add1_sum", 64'(last_sum), 64'd1017);
        chk("add1_flag", 64'(last_flag), 64'd0);
        run_op(1'b0, 1, 1'b1, 256'd18, 256'd999, 0, 1'b0, 0);
        chk("add1_cin_sum", 64'(last_sum), 64'd1018);

        run_op(1'b0, 2, 1'b0, 256'hFFFFFFFF, 256'h1, 0, 1'b0, 0);
        chk("add2_last_sum", 64'(last_sum), 64'd1);
        chk("add2_flag", 64'(last_flag), 64'd0);

        a = '1;
        b = '1;
        run_op(1'b0, 8, 1'b1, a, b, 0, 1'b0, 0);
        chk("add8_last_sum", 64'(last_sum), 64'hFFFFFFFF);
        chk("add8_flag", 64'(last_flag), 64'd1);
        chk("add8_latency", 64'(cyc_last - cyc_cmd), 64'd8);

        run_op(1'b1, 1, 1'b0, 256'd10888, 256'd98712, 1, 1'b0, 0);
        chk("sub1_sum", 64'(last_sum), 64'hFFFEA8F0);
        chk("sub1_borrow", 64'(last_flag), 64'd1);
        run_op(1'b1, 1, 1'b0, 256'd98712, 256'd10888, 1, 1'b0, 0);
        chk("sub2_sum", 64'(last_sum), 64'd87824);
        chk("sub2_borrow", 64'(last_flag), 64'd0);

        for (int i = 0; i < 8; i++) begin
            a[32*i +: 32] = $urandom;
            b[32*i +: 32] = $urandom;
        end
        run_op(1'b0, 4, 1'b0, a, b, 2, 1'b0, 0);

        run_op(1'b0, 4, 1'b0, a, b, 0, 1'b0, 2);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("abort_release_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        run_op(1'b0, 1, 1'b0, 256'd5, 256'd6, 0, 1'b0, 0);
        chk("after_abort_sum", 64'(last_sum), 64'd11);
        chk("after_abort_last", 64'(last_cnt), 64'd1);

        for (int op = 0; op < 30; op++) begin
            for (int i = 0; i < 8; i++) begin
                a[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                b[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            end
            run_op(1'($urandom), int'($urandom_range(1, 8)), 1'($urandom), a, b,
                   int'($urandom_range(0, 1)), 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
